// File: rtl/compositor_pkg.sv
// Shared types for the layer compositor: priority-table storage, colour type,
// and the identity table used at reset.
package compositor_pkg;
   localparam int NUM_LAYERS_DEF = 6;
   localparam int LAYER_IDX_W    = $clog2(NUM_LAYERS_DEF);
   localparam int MAX_LAYERS     = 16;
   localparam int TBL_IDX_W      = $clog2(MAX_LAYERS);

   typedef logic [7:0] rgb_t;

   // Sized for the largest legal layer count; a build uses the low NUM_LAYERS slots.
   typedef logic [MAX_LAYERS-1:0][TBL_IDX_W-1:0] prio_table_t;

   function automatic prio_table_t identity_table();
      prio_table_t t;
      for (int i = 0; i < MAX_LAYERS; i++) t[i] = TBL_IDX_W'(i);
      return t;
   endfunction
endpackage

// File: rtl/layer_compositor_if.sv
// Pixel stream, frame control and configuration bus of the layer compositor.
interface layer_compositor_if #(
   parameter int NUM_LAYERS = 6,
   parameter int RGB_W      = 8,
   parameter int IW         = $clog2(NUM_LAYERS)
);
   logic                             pixelValid;
   logic                             frameStart;
   logic [NUM_LAYERS-1:0]            drawReq;
   logic [NUM_LAYERS-1:0][RGB_W-1:0] layerRGB;
   logic [RGB_W-1:0]                 backGroundRGB;
   logic [NUM_LAYERS-1:0]            layerEnable;
   logic                             cfgWr;
   logic [IW-1:0]                    cfgSlot;
   logic [IW-1:0]                    cfgLayer;
   logic [RGB_W-1:0]                 RGBOut;
   logic                             RGBValid;
   logic [NUM_LAYERS-2:0]            collision;
   logic                             collisionPulse;

   modport master (
      output pixelValid, frameStart, drawReq, layerRGB, backGroundRGB,
             layerEnable, cfgWr, cfgSlot, cfgLayer,
      input  RGBOut, RGBValid, collision, collisionPulse
   );
   modport slave (
      input  pixelValid, frameStart, drawReq, layerRGB, backGroundRGB,
             layerEnable, cfgWr, cfgSlot, cfgLayer,
      output RGBOut, RGBValid, collision, collisionPulse
   );
endinterface

// File: rtl/layer_prio_table.sv
// Pending/active priority tables and layer enables; pending is copied to active
// only at frameStart so a frame never changes order midway.
module layer_prio_table
   import compositor_pkg::*;
#(
   parameter int NUM_LAYERS = 6,
   parameter int IW         = $clog2(NUM_LAYERS)
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  frameStart,
   input  logic                  cfgWr,
   input  logic [IW-1:0]         cfgSlot,
   input  logic [IW-1:0]         cfgLayer,
   input  logic [NUM_LAYERS-1:0] layerEnable,
   output prio_table_t           actTable,
   output logic [NUM_LAYERS-1:0] actEnable
);
   prio_table_t pendTable;
   logic        cfgOk;

   assign cfgOk = cfgWr && (int'(cfgSlot) < NUM_LAYERS) && (int'(cfgLayer) < NUM_LAYERS);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pendTable <= identity_table();
         actTable  <= identity_table();
         actEnable <= '1;
      end else begin
         if (cfgOk) pendTable[cfgSlot] <= TBL_IDX_W'(cfgLayer);
         // Non-blocking read: a same-cycle write waits for the next frameStart.
         if (frameStart) begin
            actTable  <= pendTable;
            actEnable <= layerEnable;
         end
      end
   end
endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: keyed/enabled requests, then priority select.
// Define COLLISION_EN to build the per-frame layer-0 overlap detector.
module layer_compositor
   import compositor_pkg::*;
#(
   parameter int               NUM_LAYERS      = 6,
   parameter int               RGB_W           = 8,
   parameter logic [RGB_W-1:0] TRANSPARENT_KEY = 8'hFF
) (
   input logic               clk,
   input logic               resetN,
   layer_compositor_if.slave bus
);
   localparam int STAGES = 2;

   prio_table_t                      actTable;
   logic [NUM_LAYERS-1:0]            actEnable;
   logic [NUM_LAYERS-1:0]            eff0, eff1;
   logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb1;
   logic [RGB_W-1:0]                 bg1, selRGB;
   logic [STAGES:1]                  vld_pipe;

   layer_prio_table #(.NUM_LAYERS(NUM_LAYERS)) u_tbl (
      .clk        (clk),
      .resetN     (resetN),
      .frameStart (bus.frameStart),
      .cfgWr      (bus.cfgWr),
      .cfgSlot    (bus.cfgSlot),
      .cfgLayer   (bus.cfgLayer),
      .layerEnable(bus.layerEnable),
      .actTable   (actTable),
      .actEnable  (actEnable)
   );

   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_eff
      assign eff0[i] = bus.drawReq[i] & actEnable[i] & (bus.layerRGB[i] != TRANSPARENT_KEY);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vld_pipe <= '0;
         eff1     <= '0;
         rgb1     <= '0;
         bg1      <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], bus.pixelValid};
         eff1     <= eff0;
         rgb1     <= bus.layerRGB;
         bg1      <= bus.backGroundRGB;
      end
   end

   // Scan from the lowest priority upward so the lowest matching slot wins last.
   always_comb begin
      selRGB = bg1;
      for (int s = NUM_LAYERS-1; s >= 0; s--)
         for (int l = 0; l < NUM_LAYERS; l++)
            if (actTable[s] == TBL_IDX_W'(l) && eff1[l]) selRGB = rgb1[l];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)          bus.RGBOut <= '0;
      else if (vld_pipe[1]) bus.RGBOut <= selRGB;
   end

   assign bus.RGBValid = vld_pipe[STAGES];

`ifdef COLLISION_EN
   logic [NUM_LAYERS-1:1] pendHit, hit1;

   assign hit1 = eff1[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){eff1[0] & vld_pipe[1]}};

   // A hit in the frameStart cycle seeds the new frame's pending set.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pendHit            <= '0;
         bus.collision      <= '0;
         bus.collisionPulse <= 1'b0;
      end else if (bus.frameStart) begin
         bus.collision      <= pendHit;
         bus.collisionPulse <= |pendHit;
         pendHit            <= hit1;
      end else begin
         bus.collisionPulse <= 1'b0;
         pendHit            <= pendHit | hit1;
      end
   end
`else
   assign bus.collision      = '0;
   assign bus.collisionPulse = 1'b0;
`endif
endmodule
